// File: rtl/aes_job_scheduler.sv
// Two-requester round-robin scheduler for one shared encrypt/decrypt core; key/seed updates applied only between jobs. `AES_SCHED_STATS_EN adds jobs_done.
// Latency: response visible CORE_LAT cycles after the accept edge; minimum job period CORE_LAT+2 cycles.
// Backpressure: reqN_ready only in IDLE with no config pending; RESP holds rsp_data until the owner's rspN_ready.
module aes_job_scheduler #(
    parameter int CORE_LAT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_mode,
    input  logic [127:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_mode,
    input  logic [127:0] req1_data,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp_data,
    input  logic         key_load,
    input  logic [255:0] key_in,
    input  logic         seed_load,
    input  logic [255:0] seed_in,
    output logic [127:0] core_in,
    output logic [255:0] core_key,
    output logic [255:0] core_seed,
    input  logic [127:0] core_out_enc,
    input  logic [127:0] core_out_dec,
`ifdef AES_SCHED_STATS_EN
    output logic [31:0]  jobs_done,
`endif
    output logic         busy
);

    localparam int CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [1:0] {IDLE, CFG, RUN, RESP} state_t;

    typedef struct packed {
        logic owner;
        logic mode;
    } job_t;

    state_t           state;
    state_t           state_nxt;
    job_t             job;
    logic [CNT_W-1:0] cnt;
    logic             last_gnt;   // 1 when req1 was granted last, so req0 wins the next tie
    logic             key_pend;
    logic             seed_pend;
    logic [255:0]     key_buf;
    logic [255:0]     seed_buf;
    logic             cfg_pend;
    logic             gnt0;
    logic             gnt1;
    logic             rsp_hs;
    logic             run_done;

    assign cfg_pend = key_pend | seed_pend;
    assign run_done = (state == RUN) && (cnt == '0);

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_pend) begin
                    state_nxt = CFG;
                end else begin
                    gnt0 = req0_valid & (~req1_valid | last_gnt);
                    gnt1 = req1_valid & (~req0_valid | ~last_gnt);
                    if (gnt0 | gnt1) begin
                        state_nxt = RUN;
                    end
                end
            end
            CFG: state_nxt = IDLE;
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_hs = job.owner ? rsp1_ready : rsp0_ready;
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by reset so a requester held valid during reset never sees a grant.
    assign req0_ready = rst & gnt0;
    assign req1_ready = rst & gnt1;
    assign rsp0_valid = (state == RESP) & ~job.owner;
    assign rsp1_valid = (state == RESP) & job.owner;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            job      <= '0;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (gnt0 | gnt1) begin
                job.owner <= gnt1;
                job.mode  <= gnt1 ? req1_mode : req0_mode;
                last_gnt  <= gnt1;
                cnt       <= CNT_W'(CORE_LAT - 1);
            end else if ((state == RUN) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_in  <= '0;
            rsp_data <= '0;
        end else begin
            if (gnt0 | gnt1) begin
                core_in <= gnt1 ? req1_data : req0_data;
            end
            if (run_done) begin
                rsp_data <= job.mode ? core_out_dec : core_out_enc;
            end
        end
    end

    // A load arriving in the CFG cycle itself survives as the next pending update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_key  <= '0;
            core_seed <= '0;
            key_pend  <= 1'b0;
            seed_pend <= 1'b0;
            key_buf   <= '0;
            seed_buf  <= '0;
        end else begin
            if (state == CFG) begin
                if (key_pend) begin
                    core_key <= key_buf;
                end
                if (seed_pend) begin
                    core_seed <= seed_buf;
                end
            end
            key_pend  <= key_load | (key_pend & (state != CFG));
            seed_pend <= seed_load | (seed_pend & (state != CFG));
            if (key_load) begin
                key_buf <= key_in;
            end
            if (seed_load) begin
                seed_buf <= seed_in;
            end
        end
    end

`ifdef AES_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jobs_done <= '0;
        end else if (rsp_hs && (jobs_done != 32'hFFFF_FFFF)) begin
            jobs_done <= jobs_done + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Bench for aes_job_scheduler: directed scenarios plus randomized traffic, all outputs checked every cycle
// against a transaction-level reference model (phase + response timestamp), with a stand-in core.
module tb_aes_job_scheduler;

    localparam int CORE_LAT = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_mode = 1'b0, req1_mode = 1'b0;
    logic [127:0] req0_data = '0, req1_data = '0;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic         key_load = 1'b0, seed_load = 1'b0;
    logic [255:0] key_in = '0, seed_in = '0;
    logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [127:0] rsp_data, core_in, core_out_enc, core_out_dec;
    logic [255:0] core_key, core_seed;
`ifdef AES_SCHED_STATS_EN
    logic [31:0]  jobs_done;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [127:0] core_ref(input logic mode, input logic [127:0] d,
                                              input logic [255:0] k, input logic [255:0] s);
        if (mode)
            return {d[63:0], d[127:64]} ^ k[255:128] ^ s[127:0];
        return d ^ k[127:0] ^ s[255:128];
    endfunction

    assign core_out_enc = core_ref(1'b0, core_in, core_key, core_seed);
    assign core_out_dec = core_ref(1'b1, core_in, core_key, core_seed);

    aes_job_scheduler #(.CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode), .req1_data(req1_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data),
        .key_load(key_load), .key_in(key_in), .seed_load(seed_load), .seed_in(seed_in),
        .core_in(core_in), .core_key(core_key), .core_seed(core_seed),
        .core_out_enc(core_out_enc), .core_out_dec(core_out_dec),
`ifdef AES_SCHED_STATS_EN
        .jobs_done(jobs_done),
`endif
        .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    // Reference model: scheduler phase, job owner and the cycle its response first appears.
    typedef enum int {M_IDLE, M_CFG, M_JOB} mphase_e;
    mphase_e      m_phase = M_IDLE;
    int           m_cyc = 0;
    int           m_first = 0;
    bit           m_owner = 1'b0;
    bit           m_last = 1'b1;
    bit           m_kp = 1'b0, m_sp = 1'b0;
    logic [255:0] m_key = '0, m_seed = '0, m_key_buf = '0, m_seed_buf = '0;
    logic [127:0] m_core_in = '0, m_rsp = '0;
    logic [31:0]  m_jobs = '0;

    always @(negedge clk) begin
        bit e_r0, e_r1, e_v0, e_v1;
        if (!rst) begin
            m_phase = M_IDLE; m_kp = 0; m_sp = 0; m_last = 1'b1;
            m_key = '0; m_seed = '0; m_key_buf = '0; m_seed_buf = '0;
            m_core_in = '0; m_rsp = '0; m_jobs = '0;
            check_eq("rst_busy", busy, 0);
            check_eq("rst_req_ready", {req1_ready, req0_ready}, 0);
            check_eq("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
            check_eq("rst_rsp_data", rsp_data, 0);
            check_eq("rst_core_in", core_in, 0);
            check_eq("rst_core_key", core_key, 0);
            check_eq("rst_core_seed", core_seed, 0);
        end else begin
            e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0;
            if (m_phase == M_IDLE && !m_kp && !m_sp) begin
                if (req0_valid && req1_valid) begin
                    e_r0 = m_last;
                    e_r1 = !m_last;
                end else begin
                    e_r0 = req0_valid;
                    e_r1 = req1_valid;
                end
            end
            if (m_phase == M_JOB && m_cyc >= m_first) begin
                e_v0 = !m_owner;
                e_v1 = m_owner;
            end
            check_eq("m_busy", busy, m_phase != M_IDLE);
            check_eq("m_req0_ready", req0_ready, e_r0);
            check_eq("m_req1_ready", req1_ready, e_r1);
            check_eq("m_rsp0_valid", rsp0_valid, e_v0);
            check_eq("m_rsp1_valid", rsp1_valid, e_v1);
            check_eq("m_core_in", core_in, m_core_in);
            check_eq("m_core_key", core_key, m_key);
            check_eq("m_core_seed", core_seed, m_seed);
            if (e_v0 || e_v1)
                check_eq("m_rsp_data", rsp_data, m_rsp);
`ifdef AES_SCHED_STATS_EN
            check_eq("m_jobs_done", jobs_done, m_jobs);
`endif
            case (m_phase)
                M_IDLE: begin
                    if (m_kp || m_sp) begin
                        m_phase = M_CFG;
                    end else if (e_r0 || e_r1) begin
                        m_owner   = e_r1;
                        m_last    = e_r1;
                        m_core_in = e_r1 ? req1_data : req0_data;
                        m_rsp     = core_ref(e_r1 ? req1_mode : req0_mode, m_core_in, m_key, m_seed);
                        m_first   = m_cyc + CORE_LAT + 1;
                        m_phase   = M_JOB;
                    end
                end
                M_CFG: begin
                    if (m_kp) m_key = m_key_buf;
                    if (m_sp) m_seed = m_seed_buf;
                    m_kp = 0;
                    m_sp = 0;
                    m_phase = M_IDLE;
                end
                default: begin
                    if (m_cyc >= m_first && (m_owner ? rsp1_ready : rsp0_ready)) begin
                        m_phase = M_IDLE;
                        if (m_jobs != 32'hFFFF_FFFF) m_jobs = m_jobs + 1;
                    end
                end
            endcase
            if (key_load) begin m_kp = 1; m_key_buf = key_in; end
            if (seed_load) begin m_sp = 1; m_seed_buf = seed_in; end
        end
        m_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        key_load = 0; seed_load = 0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input bit who);
        int k = 0;
        #1;
        while (!(who ? req1_ready : req0_ready) && k < 50) begin tick(); #1; k++; end
        check_eq("grant_wait", k < 50, 1);
    endtask

    task automatic wait_rsp(input bit who, output int k);
        k = 0;
        #1;
        while (!(who ? rsp1_valid : rsp0_valid) && k < 60) begin tick(); #1; k++; end
    endtask

    task automatic wait_idle();
        int k = 0;
        #1;
        while (busy && k < 100) begin tick(); #1; k++; end
        check_eq("idle_wait", busy, 0);
    endtask

    initial begin
        int lat;
        int ng;
        bit both, seen, kchg, hs0, hs1;
        bit gseq[4];
        logic [127:0] d;
        logic [255:0] k;

        // Single encrypt job with zero key/seed: the stand-in core returns the plaintext.
        apply_reset();
        req0_valid = 1; req0_mode = 0; req0_data = 128'h00112233445566778899AABBCCDDEEFF;
        wait_grant(0);
        tick();
        req0_valid = 0;
        wait_rsp(0, lat);
        check_eq("single_latency", lat, CORE_LAT);
        check_eq("single_rsp_data", rsp_data, 128'h00112233445566778899AABBCCDDEEFF);
        check_eq("single_rsp1_quiet", rsp1_valid, 0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        #1 check_eq("single_back_idle", busy, 0);

        // Contention from reset: grants alternate starting with req0.
        apply_reset();
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        ng = 0; both = 0;
        for (int c = 0; c < 200 && ng < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) both = 1;
            if (req0_ready) begin gseq[ng] = 0; ng++; end
            else if (req1_ready) begin gseq[ng] = 1; ng++; end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        check_eq("rr_count", ng, 4);
        for (int i = 0; i < 4; i++) check_eq($sformatf("rr_grant_%0d", i), gseq[i], i % 2);
        check_eq("rr_both_ready", both, 0);
        wait_idle();
        rsp0_ready = 0; rsp1_ready = 0;

        // Key load during RUN is deferred to a CFG cycle before the next grant.
        apply_reset();
        req0_valid = 1; req0_mode = 0; req0_data = rnd128();
        wait_grant(0);
        tick();
        req0_valid = 0;
        tick(); tick();
        key_load = 1; key_in = {256{1'b1}};
        tick();
        key_load = 0;
        kchg = 0;
        lat = 0;
        #1;
        while (!rsp0_valid && lat < 60) begin
            if (core_key != '0) kchg = 1;
            tick(); #1; lat++;
        end
        check_eq("cfg_key_held_in_run", kchg, 0);
        check_eq("cfg_rsp_seen", rsp0_valid, 1);
        rsp0_ready = 1; req0_valid = 1; req0_data = rnd128();
        tick();
        rsp0_ready = 0;
        #1;
        check_eq("cfg_blocks_grant", req0_ready, 0);
        check_eq("cfg_key_before_cfg", core_key, 0);
        tick(); #1;
        check_eq("cfg_state_busy", busy, 1);
        tick(); #1;
        check_eq("cfg_key_applied", core_key, {256{1'b1}});
        check_eq("cfg_grant_after", req0_ready, 1);
        tick();
        req0_valid = 0; rsp0_ready = 1;
        wait_idle();
        rsp0_ready = 0;

        // Response backpressure on req1 for 10 cycles.
        apply_reset();
        d = rnd128();
        req1_valid = 1; req1_mode = 1; req1_data = d;
        wait_grant(1);
        tick();
        req1_valid = 0;
        wait_rsp(1, lat);
        check_eq("bp_latency", lat, CORE_LAT);
        check_eq("bp_dec_data", rsp_data, {d[63:0], d[127:64]});
        d = rsp_data;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            check_eq("bp_rsp_stable", rsp_data, d);
            check_eq("bp_readies", {req1_ready, req0_ready}, 0);
            check_eq("bp_busy", busy, 1);
            check_eq("bp_rsp1_valid", rsp1_valid, 1);
        end
        req0_valid = 0; req1_valid = 0; rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
        #1 check_eq("bp_released", busy, 0);

        // Reset in the middle of RUN discards the job.
        apply_reset();
        k = rnd256();
        key_load = 1; key_in = k;
        tick();
        key_load = 0;
        tick(); tick();
        #1 check_eq("mr_key_applied", core_key, k);
        req0_valid = 1; req0_mode = 0; req0_data = rnd128();
        wait_grant(0);
        tick();
        req0_valid = 0;
        tick(); tick(); tick(); tick();
        rst = 0;
        #1;
        check_eq("mr_busy", busy, 0);
        check_eq("mr_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check_eq("mr_rsp_data", rsp_data, 0);
        check_eq("mr_core_in", core_in, 0);
        check_eq("mr_core_key", core_key, 0);
        tick();
        rst = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); #1;
            if (rsp0_valid || rsp1_valid) seen = 1;
        end
        check_eq("mr_no_rsp_after", seen, 0);
        check_eq("mr_idle_after", busy, 0);

        // Randomized traffic; the reference model checks every cycle.
        hs0 = 0; hs1 = 0;
        for (int c = 0; c < 2500; c++) begin
            if (!req0_valid || hs0) begin
                req0_valid = ($urandom_range(0, 1) == 1);
                req0_mode  = 1'($urandom_range(0, 1));
                req0_data  = rnd128();
            end
            if (!req1_valid || hs1) begin
                req1_valid = ($urandom_range(0, 1) == 1);
                req1_mode  = 1'($urandom_range(0, 1));
                req1_data  = rnd128();
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            key_load   = ($urandom_range(0, 19) == 0);
            key_in     = rnd256();
            seed_load  = ($urandom_range(0, 19) == 0);
            seed_in    = rnd256();
            #1;
            hs0 = req0_valid & req0_ready;
            hs1 = req1_valid & req1_ready;
            tick();
        end
        req0_valid = 0; req1_valid = 0; key_load = 0; seed_load = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        wait_idle();
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
